booth_mult_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one booth_multiplier instance among NREQ requesters.
- Accepts operand pairs over a per-requester valid/ready handshake and issues a one-cycle init to the multiplier.
- Waits for the multiplier's valid pulse and returns the 2N-bit product to the originating requester over a held response handshake.
- Includes a watchdog that returns an error response if the multiplier never completes.

---
 rtl/booth_mult_arbiter.sv | 157 +++++++++++++++
 tb/tb_booth_mult_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_arbiter.sv
// Round-robin sequencer sharing one Booth multiplier among NREQ requesters.
// Grants on mul_idle, issues a one-cycle init, returns the product or a timeout error.
module booth_mult_arbiter #(
    parameter int unsigned N       = 64,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 2 * N + 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*N-1:0]    req_multiplicand,
    input  logic [NREQ*N-1:0]    req_multiplier,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [2*N-1:0]       resp_product,
    output logic                 resp_err,
    output logic                 busy,
    output logic                 mul_init,
    input  logic                 mul_idle,
    input  logic                 mul_valid,
    output logic [N-1:0]         mul_multiplicand,
    output logic [N-1:0]         mul_multiplier,
    input  logic [2*N-1:0]       mul_product
);

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  id;
    logic [CW-1:0]   tmo_cnt;

    logic [IDW:0]    rr_sum;
    logic [IDW-1:0]  win_id;
    logic            win_found;
    logic            grant;
    logic [IDW-1:0]  next_ptr;
    logic [N-1:0]    sel_a;
    logic [N-1:0]    sel_b;
    logic            resp_accept;

    // First pending requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        rr_sum    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            rr_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (rr_sum >= (IDW+1)'(NREQ)) begin
                rr_sum = rr_sum - (IDW+1)'(NREQ);
            end
            if (!win_found && req_valid[rr_sum[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = rr_sum[IDW-1:0];
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_id == IDW'(i)) begin
                sel_a = req_multiplicand[i*N +: N];
                sel_b = req_multiplier[i*N +: N];
            end
        end
    end

    // Grants are held off while the multiplier is still busy, so a late
    // completion can never be mistaken for a new transaction's result.
    always_comb begin
        grant       = reset_L && (state == S_IDLE) && win_found && mul_idle;
        req_ready   = grant ? (NREQ'(1) << win_id) : '0;
        next_ptr    = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
        resp_accept = |(resp_valid & resp_ready);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state            <= S_IDLE;
            rr_ptr           <= '0;
            id               <= '0;
            tmo_cnt          <= '0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            mul_init         <= 1'b0;
            resp_valid       <= '0;
            resp_product     <= '0;
            resp_err         <= 1'b0;
            busy             <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        mul_multiplicand <= sel_a;
                        mul_multiplier   <= sel_b;
                        id               <= win_id;
                        rr_ptr           <= next_ptr;
                        mul_init         <= 1'b1;
                        busy             <= 1'b1;
                        state            <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mul_init <= 1'b0;
                    tmo_cnt  <= '0;
                    state    <= S_BUSY;
                end
                S_BUSY: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    // A real completion wins over a coincident timeout.
                    if (mul_valid) begin
                        resp_product <= mul_product;
                        resp_err     <= 1'b0;
                        resp_valid   <= NREQ'(1) << id;
                        state        <= S_RESP;
                    end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                        resp_product <= '0;
                        resp_err     <= 1'b1;
                        resp_valid   <= NREQ'(1) << id;
                        state        <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_accept) begin
                        resp_valid <= '0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    mul_init   <= 1'b0;
                    resp_valid <= '0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    // Structural invariants of the handshakes.
    a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_L) $onehot0(req_ready));
    a_resp_onehot:  assert property (@(posedge clk) disable iff (!reset_L) $onehot0(resp_valid));
    a_busy_state:   assert property (@(posedge clk) disable iff (!reset_L) busy == (state != S_IDLE));

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Randomized bench for booth_mult_arbiter with a behavioural multiplier and
// a round-robin/product reference model.
module tb_booth_mult_arbiter;

    localparam int unsigned N       = 8;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 2 * N + 8;
    localparam int unsigned PW      = 2 * N;

    logic              clk = 1'b0;
    logic              reset_L = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_multiplicand = '0;
    logic [NREQ*N-1:0] req_multiplier = '0;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready = '0;
    logic [PW-1:0]     resp_product;
    logic              resp_err;
    logic              busy;
    logic              mul_init;
    logic              mul_idle;
    logic              mul_valid = 1'b0;
    logic [N-1:0]      mul_multiplicand;
    logic [N-1:0]      mul_multiplier;
    logic [PW-1:0]     mul_product = '0;

    int n_tests = 0;
    int n_fail = 0;
    int ref_ptr = 0;
    int init_pulses = 0;
    logic [N-1:0] op_a [NREQ];
    logic [N-1:0] op_b [NREQ];

    // Behavioural multiplier: valid pulses mdl_delay edges after init is sampled.
    logic          mdl_idle = 1'b1;
    logic          hold_idle = 1'b0;
    int            mdl_cnt = 0;
    int            mdl_delay = N;
    logic [PW-1:0] mdl_prod = '0;

    assign mul_idle = mdl_idle & ~hold_idle;

    booth_mult_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_L(reset_L),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_multiplicand(req_multiplicand), .req_multiplier(req_multiplier),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_product(resp_product), .resp_err(resp_err), .busy(busy),
        .mul_init(mul_init), .mul_idle(mul_idle), .mul_valid(mul_valid),
        .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
        .mul_product(mul_product)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        int sx;
        int sy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        return PW'(sx * sy);
    endfunction

    always @(posedge clk) begin
        mul_valid <= 1'b0;
        if (mul_init) init_pulses <= init_pulses + 1;
        if (mdl_cnt > 1) begin
            mdl_cnt <= mdl_cnt - 1;
        end else if (mdl_cnt == 1) begin
            mdl_cnt     <= 0;
            mdl_idle    <= 1'b1;
            mul_valid   <= 1'b1;
            mul_product <= mdl_prod;
        end else if (mul_init && mdl_idle) begin
            mdl_idle <= 1'b0;
            mdl_cnt  <= mdl_delay;
            mdl_prod <= ref_mul(mul_multiplicand, mul_multiplier);
        end
    end

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int k = 0; k < int'(NREQ); k++) begin
            if (v == (NREQ'(1) << k)) return k;
        end
        return -1;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] m);
        for (int k = 0; k < int'(NREQ); k++) begin
            int j;
            j = (ptr + k) % int'(NREQ);
            if (((m >> j) & NREQ'(1)) != '0) return j;
        end
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < int'(NREQ); i++) begin
            req_multiplicand[i*N +: N] = op_a[i];
            req_multiplier[i*N +: N]   = op_b[i];
        end
    endtask

    task automatic new_ops(input int i);
        int sel;
        sel = int'($urandom_range(0, 7));
        op_a[i] = (sel == 0) ? {1'b1, {(N-1){1'b0}}} : (sel == 1) ? {1'b0, {(N-1){1'b1}}} : N'($urandom);
        op_b[i] = (sel == 2) ? {1'b1, {(N-1){1'b0}}} : (sel == 3) ? {N{1'b1}} : N'($urandom);
        drive_ops();
    endtask

    task automatic wait_grant(output int gid);
        gid = -1;
        for (int c = 0; c < 300 && gid < 0; c++) begin
            if ((req_valid & req_ready) != '0) gid = oh_idx(req_valid & req_ready);
            else begin @(posedge clk); #1; end
        end
    endtask

    // lat is the number of edges after the handshake edge until resp_valid shows.
    task automatic wait_resp(input int gid, input bit drop, output logic [NREQ-1:0] rv,
                             output logic [PW-1:0] p, output logic e, output int lat);
        lat = -1; rv = '0; p = '0; e = 1'b0;
        for (int c = 0; c < 200 && rv == '0; c++) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 0 && gid >= 0) begin
                if (drop) req_valid = req_valid & ~(NREQ'(1) << gid);
                new_ops(gid);
            end
            rv = resp_valid; p = resp_product; e = resp_err;
        end
    endtask

    task automatic accept(input logic [NREQ-1:0] owner, input int delay);
        repeat (delay) begin @(posedge clk); #1; end
        resp_ready = owner;
        @(posedge clk); #1;
        resp_ready = '0;
    endtask

    task automatic run_txn(input bit drop, input int acc_delay, output int gid, output int exp_g,
                           output logic [NREQ-1:0] rv, output logic [PW-1:0] p,
                           output logic [PW-1:0] exp_p, output logic e, output int lat);
        rv = '0; p = '0; e = 1'b0; lat = -1; exp_p = '0;
        exp_g = rr_pick(ref_ptr, req_valid);
        wait_grant(gid);
        if (exp_g >= 0) begin
            exp_p   = ref_mul(op_a[exp_g], op_b[exp_g]);
            ref_ptr = (exp_g + 1) % int'(NREQ);
        end
        if (gid >= 0) begin
            wait_resp(gid, drop, rv, p, e, lat);
            if (rv != '0) accept(rv, acc_delay);
        end
    endtask

    task automatic test_reset();
        req_valid = '1;
        #2 reset_L = 1'b0;
        #1;
        n_tests++;
        if ({req_ready, resp_valid} !== '0) begin
            n_fail++; $display("FAIL reset_handshake: got %b expected 0", {req_ready, resp_valid});
        end
        n_tests++;
        if ({resp_product, resp_err} !== '0) begin
            n_fail++; $display("FAIL reset_resp: got %h expected 0", {resp_product, resp_err});
        end
        n_tests++;
        if ({busy, mul_init, mul_multiplicand, mul_multiplier} !== '0) begin
            n_fail++; $display("FAIL reset_mul: got %h expected 0", {busy, mul_init, mul_multiplicand, mul_multiplier});
        end
        req_valid = '0;
        ref_ptr = 0;
        repeat (2) @(posedge clk);
        #1 reset_L = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int gid, exp_g, lat, p0;
        logic [NREQ-1:0] rv;
        logic [PW-1:0] p;
        logic e;
        op_a[0] = N'(7);
        op_b[0] = N'(-3);
        drive_ops();
        req_valid = NREQ'(1);
        #1;
        n_tests++;
        if (req_ready !== NREQ'(1)) begin
            n_fail++; $display("FAIL single_ready: got %b expected %b", req_ready, NREQ'(1));
        end
        p0 = init_pulses;
        exp_g = rr_pick(ref_ptr, req_valid);
        ref_ptr = (exp_g + 1) % int'(NREQ);
        wait_grant(gid);
        wait_resp(gid, 1'b1, rv, p, e, lat);
        n_tests++;
        if (rv !== NREQ'(1) || p !== 16'hFFEB || e !== 1'b0) begin
            n_fail++; $display("FAIL single_resp: got rv=%b p=%h err=%b expected rv=0001 p=ffeb err=0", rv, p, e);
        end
        n_tests++;
        if (lat !== int'(N + 2)) begin
            n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat, N + 2);
        end
        n_tests++;
        if (init_pulses - p0 !== 1) begin
            n_fail++; $display("FAIL single_init_pulse: got %0d expected 1", init_pulses - p0);
        end
        // Only the owner's resp_ready may complete the response.
        resp_ready = ~NREQ'(1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (resp_valid !== NREQ'(1) || resp_product !== 16'hFFEB || busy !== 1'b1) begin
                n_fail++; $display("FAIL single_hold: got rv=%b p=%h busy=%b expected rv=0001 p=ffeb busy=1", resp_valid, resp_product, busy);
            end
        end
        resp_ready = '0;
        accept(rv, 0);
        n_tests++;
        if (resp_valid !== '0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_release: got rv=%b busy=%b expected 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        int gid, exp_g, lat;
        int cnt [NREQ];
        logic [NREQ-1:0] rv;
        logic [PW-1:0] p, exp_p;
        logic e;
        for (int i = 0; i < int'(NREQ); i++) begin new_ops(i); cnt[i] = 0; end
        req_valid = '1;
        #1;
        for (int t = 0; t < 8; t++) begin
            run_txn(1'b0, int'($urandom_range(0, 2)), gid, exp_g, rv, p, exp_p, e, lat);
            if (gid >= 0) cnt[gid]++;
            n_tests++;
            if (gid !== exp_g || rv !== (NREQ'(1) << exp_g)) begin
                n_fail++; $display("FAIL rr_grant: got id=%0d rv=%b expected id=%0d", gid, rv, exp_g);
            end
            n_tests++;
            if (p !== exp_p || e !== 1'b0) begin
                n_fail++; $display("FAIL rr_product: got %h err=%b expected %h err=0", p, e, exp_p);
            end
            n_tests++;
            if (req_ready !== (NREQ'(1) << rr_pick(ref_ptr, req_valid))) begin
                n_fail++; $display("FAIL rr_next_grant: got %b expected %b", req_ready, NREQ'(1) << rr_pick(ref_ptr, req_valid));
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            n_tests++;
            if (cnt[i] !== 2) begin
                n_fail++; $display("FAIL rr_fairness: requester %0d got %0d grants expected 2", i, cnt[i]);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_pointer_skip();
        int gid, exp_g, lat;
        logic [NREQ-1:0] rv;
        logic [PW-1:0] p, exp_p;
        logic e;
        new_ops(0);
        req_valid = NREQ'(1);
        #1;
        run_txn(1'b1, 0, gid, exp_g, rv, p, exp_p, e, lat);
        new_ops(0); new_ops(3);
        req_valid = 4'b1001;
        #1;
        run_txn(1'b0, 0, gid, exp_g, rv, p, exp_p, e, lat);
        n_tests++;
        if (gid !== 3 || p !== exp_p) begin
            n_fail++; $display("FAIL skip_first: got id=%0d p=%h expected id=3 p=%h", gid, p, exp_p);
        end
        run_txn(1'b0, 0, gid, exp_g, rv, p, exp_p, e, lat);
        n_tests++;
        if (gid !== 0 || p !== exp_p) begin
            n_fail++; $display("FAIL skip_second: got id=%0d p=%h expected id=0 p=%h", gid, p, exp_p);
        end
        req_valid = '0;
    endtask

    task automatic test_idle_gating();
        int gid, exp_g, lat, bad;
        logic [NREQ-1:0] rv;
        logic [PW-1:0] p, exp_p;
        logic e;
        bad = 0;
        hold_idle = 1'b1;
        new_ops(2);
        req_valid = 4'b0100;
        #1;
        for (int c = 0; c < 6; c++) begin
            if (req_ready !== '0 || busy !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL idle_gate: got %0d granted cycles expected 0", bad);
        end
        hold_idle = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL idle_release: got %b expected 0100", req_ready);
        end
        run_txn(1'b1, 0, gid, exp_g, rv, p, exp_p, e, lat);
        n_tests++;
        if (gid !== 2 || p !== exp_p || lat !== int'(N + 2)) begin
            n_fail++; $display("FAIL idle_txn: got id=%0d p=%h lat=%0d expected id=2 p=%h lat=%0d", gid, p, lat, exp_p, N + 2);
        end
    endtask

    task automatic test_timeout();
        int gid, exp_g, lat, bad, after;
        logic [NREQ-1:0] rv;
        logic [PW-1:0] p, exp_p;
        logic e, seen;
        mdl_delay = int'(TIMEOUT) + 16;
        gid = int'($urandom_range(0, NREQ - 1));
        new_ops(gid);
        req_valid = NREQ'(1) << gid;
        #1;
        run_txn(1'b1, 1, gid, exp_g, rv, p, exp_p, e, lat);
        n_tests++;
        if (rv !== (NREQ'(1) << exp_g) || e !== 1'b1 || p !== '0) begin
            n_fail++; $display("FAIL timeout_resp: got rv=%b err=%b p=%h expected rv=%b err=1 p=0", rv, e, p, NREQ'(1) << exp_g);
        end
        n_tests++;
        if (lat !== int'(TIMEOUT + 1)) begin
            n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", lat, TIMEOUT + 1);
        end
        seen = 1'b0; bad = 0; after = 0;
        for (int c = 0; c < 80 && after < 6; c++) begin
            @(posedge clk); #1;
            if (mul_valid) seen = 1'b1;
            if (resp_valid !== '0 || busy !== 1'b0) bad++;
            if (seen) after++;
        end
        n_tests++;
        if (seen !== 1'b1 || bad !== 0) begin
            n_fail++; $display("FAIL late_valid: got seen=%b stray_cycles=%0d expected seen=1 stray=0", seen, bad);
        end
        mdl_delay = N;
    endtask

    task automatic test_async_reset();
        int gid, exp_g, lat;
        logic [NREQ-1:0] rv;
        logic [PW-1:0] p, exp_p;
        logic e;
        new_ops(2);
        req_valid = 4'b0100;
        #1;
        wait_grant(gid);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #2 reset_L = 1'b0;
        #1;
        n_tests++;
        if ({busy, mul_init, resp_valid, resp_err} !== '0) begin
            n_fail++; $display("FAIL areset_ctrl: got %b expected 0", {busy, mul_init, resp_valid, resp_err});
        end
        n_tests++;
        if ({mul_multiplicand, mul_multiplier, resp_product} !== '0) begin
            n_fail++; $display("FAIL areset_data: got %h expected 0", {mul_multiplicand, mul_multiplier, resp_product});
        end
        ref_ptr = 0;
        @(posedge clk);
        #3 reset_L = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (resp_valid !== '0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL areset_abandon: got rv=%b busy=%b expected 0 0", resp_valid, busy);
        end
        for (int i = 0; i < int'(NREQ); i++) new_ops(i);
        req_valid = '1;
        #1;
        run_txn(1'b1, 0, gid, exp_g, rv, p, exp_p, e, lat);
        n_tests++;
        if (gid !== 0 || p !== exp_p || e !== 1'b0 || lat !== int'(N + 2)) begin
            n_fail++; $display("FAIL areset_next: got id=%0d p=%h err=%b lat=%0d expected id=0 p=%h err=0 lat=%0d", gid, p, e, lat, exp_p, N + 2);
        end
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int gid, exp_g, lat;
        logic [NREQ-1:0] rv, add;
        logic [PW-1:0] p, exp_p;
        logic e;
        for (int t = 0; t < 12; t++) begin
            add = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if ((req_valid | add) == '0) add = NREQ'(1) << $urandom_range(0, NREQ - 1);
            for (int i = 0; i < int'(NREQ); i++) begin
                if ((((add & ~req_valid) >> i) & NREQ'(1)) != '0) new_ops(i);
            end
            req_valid = req_valid | add;
            #1;
            run_txn(1'b1, int'($urandom_range(0, 3)), gid, exp_g, rv, p, exp_p, e, lat);
            n_tests++;
            if (gid !== exp_g || rv !== (NREQ'(1) << exp_g)) begin
                n_fail++; $display("FAIL rand_grant: got id=%0d rv=%b expected id=%0d", gid, rv, exp_g);
            end
            n_tests++;
            if (p !== exp_p || e !== 1'b0 || lat !== int'(N + 2)) begin
                n_fail++; $display("FAIL rand_product: got p=%h err=%b lat=%0d expected p=%h err=0 lat=%0d", p, e, lat, exp_p, N + 2);
            end
        end
        req_valid = '0;
    endtask

    initial begin
        for (int i = 0; i < int'(NREQ); i++) new_ops(i);
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_skip();
        test_idle_gating();
        test_timeout();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
